// File: rtl/commit_stage.sv
// commit_stage: pipe-6 writeback/commit with misaligned-access trap and instret counter.
//   Inputs : clk, nrst (sync, active-high), pipe-5 instruction fields (valid5..auipc5),
//            mem_out6/addr_misaligned6 (data-memory results for the pipe-6 instruction),
//            stall (hold pipe 6), trap_ack (front end took the redirect).
//   Outputs: register-file write port, identical forwarding copy, trap pulse/pc, instret.
module commit_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             valid5,
    input  logic             we5,
    input  logic             ld5,
    input  logic             st5,
    input  logic [2:0]       fn5,
    input  logic [4:0]       rd5,
    input  logic [XLEN-1:0]  alu_res5,
    input  logic [XLEN-1:0]  U_imm5,
    input  logic [XLEN-1:0]  pc5,
    input  logic             j5,
    input  logic             jr5,
    input  logic             LUI5,
    input  logic             auipc5,
    input  logic [XLEN-1:0]  mem_out6,
    input  logic             addr_misaligned6,
    input  logic             stall,
    input  logic             trap_ack,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             trap,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic {RUN, TRAP} state_t;
    state_t           state_q, state_d;
    logic             valid6_q, we6_q, ld6_q, st6_q, j6_q, jr6_q, lui6_q, auipc6_q;
    logic [2:0]       fn6_q;
    logic [4:0]       rd6_q;
    logic [XLEN-1:0]  alu6_q, uimm6_q, pc6_q, trap_pc_q, wb;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             trap_q, fault, run, enter_trap, retire;
    logic             unused_fn6;
    // funct3 travels with the instruction but the load data arrives already extended
    assign unused_fn6 = ^fn6_q;
    always_comb begin
        run        = state_q == RUN;
        fault      = valid6_q & (ld6_q | st6_q) & addr_misaligned6;
        enter_trap = run & fault & ~stall;
        retire     = valid6_q & ~fault & run & ~stall;
        state_d    = run ? (enter_trap ? TRAP : RUN) : (trap_ack ? RUN : TRAP);
        instret_d  = instret_q + CNT_W'(retire);
        wb         = ld6_q            ? mem_out6 :
                     (j6_q | jr6_q)   ? pc6_q + XLEN'(4) :
                     lui6_q           ? uimm6_q :
                     auipc6_q         ? pc6_q + uimm6_q : alu6_q;
        rf_we      = valid6_q & we6_q & (rd6_q != 5'd0) & ~fault & run;
        rf_waddr   = rd6_q;
        rf_wdata   = valid6_q ? wb : '0;
    end
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;
    assign trap      = trap_q;
    assign trap_pc   = trap_pc_q;
    assign instret   = instret_q;
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q   <= RUN;
            valid6_q  <= 1'b0;
            we6_q     <= 1'b0;
            ld6_q     <= 1'b0;
            st6_q     <= 1'b0;
            j6_q      <= 1'b0;
            jr6_q     <= 1'b0;
            lui6_q    <= 1'b0;
            auipc6_q  <= 1'b0;
            fn6_q     <= '0;
            rd6_q     <= '0;
            alu6_q    <= '0;
            uimm6_q   <= '0;
            pc6_q     <= '0;
            trap_pc_q <= '0;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= enter_trap;
            instret_q <= instret_d;
            if (enter_trap) trap_pc_q <= pc6_q;
            if (!stall) begin
                // nothing is accepted while trapped or on the edge that enters the trap
                valid6_q <= valid5 & run & ~enter_trap;
                we6_q    <= we5;
                ld6_q    <= ld5;
                st6_q    <= st5;
                j6_q     <= j5;
                jr6_q    <= jr5;
                lui6_q   <= LUI5;
                auipc6_q <= auipc5;
                fn6_q    <= fn5;
                rd6_q    <= rd5;
                alu6_q   <= alu_res5;
                uimm6_q  <= U_imm5;
                pc6_q    <= pc5;
            end
        end
    end
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed self-checking bench for commit_stage.
module tb_commit_stage;
    logic        clk = 1'b0, nrst = 1'b1;
    logic        valid5, we5, ld5, st5, j5, jr5, LUI5, auipc5, stall, trap_ack, addr_misaligned6;
    logic [2:0]  fn5;
    logic [4:0]  rd5;
    logic [31:0] alu_res5, U_imm5, pc5, mem_out6;
    logic        rf_we, fwd_valid, trap;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, trap_pc;
    logic [63:0] instret;
    logic        w_rf_we, w_fwd_valid, w_trap;
    logic [4:0]  w_rf_waddr, w_fwd_rd;
    logic [31:0] w_rf_wdata, w_fwd_data, w_trap_pc;
    logic [1:0]  w_instret;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    commit_stage dut (
        .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .ld5(ld5), .st5(st5), .fn5(fn5),
        .rd5(rd5), .alu_res5(alu_res5), .U_imm5(U_imm5), .pc5(pc5), .j5(j5), .jr5(jr5),
        .LUI5(LUI5), .auipc5(auipc5), .mem_out6(mem_out6), .addr_misaligned6(addr_misaligned6),
        .stall(stall), .trap_ack(trap_ack), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .trap(trap), .trap_pc(trap_pc), .instret(instret)
    );

    // narrow counter copy so wrap-around is reachable in a few retires
    commit_stage #(.XLEN(32), .CNT_W(2)) dut_w (
        .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .ld5(ld5), .st5(st5), .fn5(fn5),
        .rd5(rd5), .alu_res5(alu_res5), .U_imm5(U_imm5), .pc5(pc5), .j5(j5), .jr5(jr5),
        .LUI5(LUI5), .auipc5(auipc5), .mem_out6(mem_out6), .addr_misaligned6(addr_misaligned6),
        .stall(stall), .trap_ack(trap_ack), .rf_we(w_rf_we), .rf_waddr(w_rf_waddr),
        .rf_wdata(w_rf_wdata), .fwd_valid(w_fwd_valid), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
        .trap(w_trap), .trap_pc(w_trap_pc), .instret(w_instret)
    );

    task automatic clear_in();
        valid5 = 0; we5 = 0; ld5 = 0; st5 = 0; j5 = 0; jr5 = 0; LUI5 = 0; auipc5 = 0;
        fn5 = 0; rd5 = 0; alu_res5 = 0; U_imm5 = 0; pc5 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        clear_in();
        valid5 = 1; we5 = 1; rd5 = rd; alu_res5 = v;
    endtask

    task automatic test_reset();
        clear_in();
        stall = 0; trap_ack = 0; addr_misaligned6 = 0; mem_out6 = 0;
        nrst = 1; valid5 = 1; we5 = 1; rd5 = 3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0h exp 0", rf_we); end
            checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0h exp 0", instret); end
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %0h exp 0", trap); end
        end
        nrst = 0; clear_in();
        #1;
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0h exp 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0h exp 0", rf_wdata); end
        checks++; if (trap_pc !== 32'd0) begin errors++; $display("FAIL reset_trap_pc got %0h exp 0", trap_pc); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_we got %0h exp 0", rf_we); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL post_reset_instret got %0h exp 0", instret); end
    endtask

    task automatic test_alu_lui();
        alu(5, 32'h12);
        tick();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %0h exp 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0h exp 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h12) begin errors++; $display("FAIL alu_wdata got %0h exp 12", rf_wdata); end
        checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h12}) begin errors++; $display("FAIL alu_fwd got %0h/%0h/%0h exp 1/5/12", fwd_valid, fwd_rd, fwd_data); end
        alu(6, 32'h0); LUI5 = 1; U_imm5 = 32'hABCDE000;
        tick();
        checks++; if (rf_wdata !== 32'hABCDE000) begin errors++; $display("FAIL lui_wdata got %0h exp abcde000", rf_wdata); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL lui_instret got %0d exp 1", instret); end
        clear_in();
        tick();
        checks++; if (instret !== 64'd2) begin errors++; $display("FAIL alu_lui_instret got %0d exp 2", instret); end
    endtask

    task automatic test_jal_auipc();
        alu(1, 32'hDEAD); j5 = 1; pc5 = 32'h100;
        tick();
        checks++; if (rf_wdata !== 32'h104) begin errors++; $display("FAIL jal_wdata got %0h exp 104", rf_wdata); end
        alu(2, 32'hDEAD); auipc5 = 1; pc5 = 32'h200; U_imm5 = 32'h1000;
        tick();
        checks++; if (rf_wdata !== 32'h1200) begin errors++; $display("FAIL auipc_wdata got %0h exp 1200", rf_wdata); end
        alu(0, 32'h55);
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %0h exp 0", rf_we); end
        checks++; if (instret !== 64'd4) begin errors++; $display("FAIL jal_instret got %0d exp 4", instret); end
        clear_in();
        tick();
        checks++; if (instret !== 64'd5) begin errors++; $display("FAIL x0_instret got %0d exp 5", instret); end
    endtask

    task automatic test_load();
        alu(7, 32'h3); ld5 = 1;
        tick();
        mem_out6 = 32'hFFFFFF80;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL load_we got %0h exp 1", rf_we); end
        checks++; if (rf_wdata !== 32'hFFFFFF80) begin errors++; $display("FAIL load_wdata got %0h exp ffffff80", rf_wdata); end
        alu(0, 32'h3); ld5 = 1;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL load_x0_we got %0h exp 0", rf_we); end
        clear_in();
        tick();
        mem_out6 = 0;
        checks++; if (instret !== 64'd7) begin errors++; $display("FAIL load_instret got %0d exp 7", instret); end
    endtask

    task automatic test_trap();
        alu(8, 32'h1); ld5 = 1; pc5 = 32'h40;
        tick();
        addr_misaligned6 = 1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL fault_we got %0h exp 0", rf_we); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL fault_trap_early got %0h exp 0", trap); end
        alu(9, 32'h9);
        tick();
        addr_misaligned6 = 0;
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_pulse got %0h exp 1", trap); end
        checks++; if (trap_pc !== 32'h40) begin errors++; $display("FAIL trap_pc got %0h exp 40", trap_pc); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL trap_drop_we got %0h exp 0", rf_we); end
        for (int i = 0; i < 3; i++) begin
            alu(5'(12 + i), 32'h5);
            tick();
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_held_pulse%0d got %0h exp 0", i, trap); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL trap_held_we%0d got %0h exp 0", i, rf_we); end
            checks++; if (instret !== 64'd7) begin errors++; $display("FAIL trap_held_instret%0d got %0d exp 7", i, instret); end
        end
        alu(10, 32'h6); trap_ack = 1;
        tick();
        trap_ack = 0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ack_edge_we got %0h exp 0", rf_we); end
        alu(11, 32'h77);
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'h77}) begin errors++; $display("FAIL post_ack_write got %0h/%0h/%0h exp 1/b/77", rf_we, rf_waddr, rf_wdata); end
        clear_in();
        tick();
        checks++; if (instret !== 64'd8) begin errors++; $display("FAIL post_ack_instret got %0d exp 8", instret); end
    endtask

    task automatic test_stall();
        alu(13, 32'h99);
        tick();
        alu(14, 32'hAA); stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd13, 32'h99}) begin errors++; $display("FAIL stall_hold%0d got %0h/%0h/%0h exp 1/d/99", i, rf_we, rf_waddr, rf_wdata); end
            checks++; if (instret !== 64'd8) begin errors++; $display("FAIL stall_instret%0d got %0d exp 8", i, instret); end
        end
        stall = 0; clear_in();
        tick();
        checks++; if (instret !== 64'd9) begin errors++; $display("FAIL unstall_instret got %0d exp 9", instret); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL unstall_we got %0h exp 0", rf_we); end
    endtask

    task automatic test_wrap();
        nrst = 1;
        tick();
        nrst = 0;
        for (int i = 0; i < 3; i++) begin
            alu(1, 32'(i));
            tick();
        end
        clear_in();
        tick();
        checks++; if (w_instret !== 2'd3) begin errors++; $display("FAIL wrap_max got %0d exp 3", w_instret); end
        alu(1, 32'h4);
        tick();
        clear_in();
        tick();
        checks++; if (w_instret !== 2'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", w_instret); end
        checks++; if (instret !== 64'd4) begin errors++; $display("FAIL wrap_wide got %0d exp 4", instret); end
    endtask

    initial begin
        test_reset();
        test_alu_lui();
        test_jal_auipc();
        test_load();
        test_trap();
        test_stall();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
